cpu_sequencer: RTL
==================

Name: cpu_sequencer

Overview:
- Multi-cycle control unit for the 8-bit accumulator CPU.
- Fetches each instruction, latches its 4-bit opcode and 4-bit address, and sequences the program counter, MAR, RAM, IR, A/B registers and ALU through per-opcode T-states.
- Uses a ready handshake with RAM and a start/done handshake with multi-cycle MUL/DIV.
- Provides halt, fault and retired-instruction status.

Parameters:
- OPW, 4, opcode width
- ADW, 4, address width
- MEM_TMO, 15, max cycles waiting for mem_ready before fault
- ALU_TMO, 31, max cycles waiting for alu_done before fault

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- run  input  1  permit to start the next instruction
- ir_op  input  OPW  opcode field from instruction register
- ir_addr  input  ADW  address field from instruction register
- mem_ready  input  1  RAM read data valid this cycle
- alu_done  input  1  multi-cycle ALU result valid
- pc_en  output  1  PC drives bus_i
- pc_inc  output  1  PC increment
- pc_load  output  1  PC loads jmp_addr
- jmp_addr  output  ADW  latched address for JMP
- mar_load  output  1  MAR captures its source
- mar_sel  output  1  0=bus_i (PC), 1=latched address
- ram_rd  output  1  RAM read request
- ir_load  output  1  IR captures RAM data
- a_load  output  1  A captures RAM data
- b_load  output  1  B captures result (RAM or ALU)
- alu_op  output  3  0=pass, 1=add, 2=sub, 3=mul, 4=div
- alu_start  output  1  one-cycle MUL/DIV start pulse
- halted  output  1  in HALT state
- fault  output  1  timeout or illegal opcode seen (sticky)
- instr_cnt  output  8  retired-instruction count

Behaviour:
- Opcodes: LDA=1000, LDB=0100, ADD=0010, SUB=0001, MUL=1100, DIV=1010, JMP=1001, HLT=1111. All other codes are illegal.
- States: IDLE, F_ADDR, F_WAIT, DECODE, X_ADDR, X_WAIT, X_ALU, HALT.
- Strobes are combinational from the state register, latched opcode, mem_ready and alu_done. Strobes are 0 in every state/condition not listed below.
- halted, fault, instr_cnt, jmp_addr and the latched opcode/address are registered.
- Reset (async, low): state=IDLE; all strobes 0; halted=0; fault=0; instr_cnt=0; latches cleared. Reset asserted mid-instruction aborts immediately with no partial loads.
- IDLE: if run=1, go to F_ADDR next cycle; otherwise stay.
- F_ADDR (1 cycle): pc_en=1, mar_load=1, mar_sel=0.
- F_WAIT: ram_rd=1 until mem_ready. On the mem_ready cycle: ir_load=1, pc_inc=1, go to DECODE.
- DECODE (1 cycle): latch ir_op and ir_addr. Then:
  - JMP: pc_load=1, jmp_addr=ir_addr, retire.
  - HLT: go to HALT, retire.
  - Illegal opcode: fault=1, retire as NOP.
  - Otherwise: go to X_ADDR.
- X_ADDR (1 cycle): mar_load=1, mar_sel=1.
- X_WAIT: ram_rd=1 until mem_ready. On the mem_ready cycle:
  - LDA: a_load=1.
  - LDB: b_load=1, alu_op=pass.
  - ADD/SUB: b_load=1, alu_op=add/sub (A op mem, 8-bit, wraps modulo 256, no carry out).
  - MUL/DIV: alu_start=1, alu_op held, go to X_ALU. B receives the low 8 bits; divide by 0 is the ALU's concern.
  - LDA, LDB, ADD, SUB retire on this cycle.
- X_ALU: alu_op held. On alu_done: b_load=1, retire. An alu_done arriving in the same cycle as alu_start is ignored.
- Retire: instr_cnt+1 (wraps 255→0). Next state is F_ADDR if run=1, IDLE if run=0. HLT instead goes to HALT.
- run is sampled only in IDLE and at retire; deasserting run never interrupts an instruction in progress.
- Watchdog: counts consecutive cycles in F_WAIT/X_WAIT (and separately in X_ALU). Exceeding MEM_TMO (or ALU_TMO): fault=1, go to HALT, no load strobe, no retire.
- HALT: halted=1, all strobes 0. HALT is left only by reset.
- Latency with mem_ready immediate:
  - JMP/HLT: 3 cycles.
  - LDA/LDB/ADD/SUB: 5 cycles.
  - MUL/DIV: 5 cycles + ALU latency.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams.
  - alu_op encodings.
  - state enum typedef.
  - control-word struct (pc_en…alu_start) for reuse by datapath and bench.
- One sub-module, seq_watchdog:
  - parameterised down-counter with clear, enable and expire output.
  - instantiated twice (MEM, ALU).

Test Plan:
- Program LDA 3, ADD 1, HLT with mem_ready tied 1 and mem[3]=0x05, mem[1]=0x81 → a_load after 5 cycles; b_load with alu_op=1 on cycle 10; halted=1 after 13 cycles; instr_cnt=3.
- MUL with alu_done returned 4 cycles after alu_start → exactly one alu_start pulse; b_load coincides with alu_done; no b_load during waiting.
- JMP 0x6 at PC=2 → pc_load=1, jmp_addr=0x6 in DECODE; next F_ADDR follows with pc_en=1; instr_cnt+1.
- mem_ready held 0 in X_WAIT → fault=1 and HALT after 16 cycles; no a_load/b_load; instr_cnt unchanged.
- Illegal opcode 0011, then run=0 at retire → fault=1, instr_cnt+1, state IDLE; no further strobes until run=1.
- reset pulled low during X_ALU → all strobes 0 immediately, instr_cnt=0, fault=0; restart fetches cleanly.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcodes, ALU encodings, sequencer states and control word for the 8-bit accumulator CPU.
package cpu_pkg;

   localparam logic [3:0] OP_LDA = 4'b1000;
   localparam logic [3:0] OP_LDB = 4'b0100;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b1100;
   localparam logic [3:0] OP_DIV = 4'b1010;
   localparam logic [3:0] OP_JMP = 4'b1001;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_MUL  = 3'd3;
   localparam logic [2:0] ALU_DIV  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE, S_F_ADDR, S_F_WAIT, S_DECODE, S_X_ADDR, S_X_WAIT, S_X_ALU, S_HALT
   } state_e;

   typedef struct packed {
      logic       pc_en;
      logic       pc_inc;
      logic       pc_load;
      logic       mar_load;
      logic       mar_sel;
      logic       ram_rd;
      logic       ir_load;
      logic       a_load;
      logic       b_load;
      logic [2:0] alu_op;
      logic       alu_start;
   } ctrl_t;

   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_JMP, OP_HLT: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_multi(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic logic [2:0] alu_of(input logic [3:0] op);
      case (op)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         OP_MUL:  return ALU_MUL;
         OP_DIV:  return ALU_DIV;
         default: return ALU_PASS;
      endcase
   endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Handshake watchdog: reloads to TMO while cleared, counts down while enabled,
// and flags expiry on the first enabled cycle after TMO cycles have elapsed.
module seq_watchdog #(
   parameter int TMO = 15
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int CW = $clog2(TMO + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = CW'(TMO);
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= CW'(TMO);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// state    | meaning
// IDLE     | waiting for run
// F_ADDR   | PC -> MAR
// F_WAIT   | instruction read, IR load + PC increment on mem_ready
// DECODE   | latch opcode/address; JMP/HLT/illegal finish here
// X_ADDR   | latched address -> MAR
// X_WAIT   | operand read, load or ALU start on mem_ready
// X_ALU    | waiting for MUL/DIV done
// HALT     | stopped until reset
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int OPW     = 4,
   parameter int ADW     = 4,
   parameter int MEM_TMO = 15,
   parameter int ALU_TMO = 31
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           run_i,
   input  logic [OPW-1:0] ir_op_i,
   input  logic [ADW-1:0] ir_addr_i,
   input  logic           mem_ready_i,
   input  logic           alu_done_i,
   output logic           pc_en_o,
   output logic           pc_inc_o,
   output logic           pc_load_o,
   output logic [ADW-1:0] jmp_addr_o,
   output logic           mar_load_o,
   output logic           mar_sel_o,
   output logic           ram_rd_o,
   output logic           ir_load_o,
   output logic           a_load_o,
   output logic           b_load_o,
   output logic [2:0]     alu_op_o,
   output logic           alu_start_o,
   output logic           halted_o,
   output logic           fault_o,
   output logic [7:0]     instr_cnt_o
);
   state_e         state_q, state_d, ret_state;
   logic [OPW-1:0] op_q, op_d;
   logic [ADW-1:0] addr_q, addr_d;
   logic           fault_q, halted_q;
   logic [7:0]     cnt_q;
   logic           retire, fault_set;
   logic           mem_wait, mem_exp, alu_exp;
   ctrl_t          ctrl;

   assign mem_wait = (state_q == S_F_WAIT) || (state_q == S_X_WAIT);

   seq_watchdog #(.TMO(MEM_TMO)) u_mem_wd (
      .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(!mem_wait), .en_i(mem_wait), .expired_o(mem_exp)
   );

   seq_watchdog #(.TMO(ALU_TMO)) u_alu_wd (
      .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(state_q != S_X_ALU), .en_i(state_q == S_X_ALU),
      .expired_o(alu_exp)
   );

   assign op_d   = (state_q == S_DECODE) ? ir_op_i   : op_q;
   assign addr_d = (state_q == S_DECODE) ? ir_addr_i : addr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         addr_q   <= '0;
         fault_q  <= 1'b0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         fault_q  <= fault_q || fault_set;
         halted_q <= (state_d == S_HALT);
         cnt_q    <= cnt_q + 8'(retire);
      end
   end

   always_comb begin
      state_d   = state_q;
      retire    = 1'b0;
      fault_set = 1'b0;
      ret_state = run_i ? S_F_ADDR : S_IDLE;
      case (state_q)
         S_IDLE:   if (run_i) state_d = S_F_ADDR;
         S_F_ADDR: state_d = S_F_WAIT;
         S_F_WAIT: begin
            if (mem_ready_i) begin
               state_d = S_DECODE;
            end else if (mem_exp) begin
               state_d   = S_HALT;
               fault_set = 1'b1;
            end
         end
         S_DECODE: begin
            if (ir_op_i == OP_HLT) begin
               state_d = S_HALT;
               retire  = 1'b1;
            end else if ((ir_op_i == OP_JMP) || !is_legal(ir_op_i)) begin
               state_d   = ret_state;
               retire    = 1'b1;
               fault_set = !is_legal(ir_op_i);
            end else begin
               state_d = S_X_ADDR;
            end
         end
         S_X_ADDR: state_d = S_X_WAIT;
         S_X_WAIT: begin
            if (mem_ready_i) begin
               if (is_multi(op_q)) begin
                  state_d = S_X_ALU;
               end else begin
                  state_d = ret_state;
                  retire  = 1'b1;
               end
            end else if (mem_exp) begin
               state_d   = S_HALT;
               fault_set = 1'b1;
            end
         end
         S_X_ALU: begin
            // alu_done is only looked at from here, so a done coincident with start is ignored
            if (alu_done_i) begin
               state_d = ret_state;
               retire  = 1'b1;
            end else if (alu_exp) begin
               state_d   = S_HALT;
               fault_set = 1'b1;
            end
         end
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         S_F_ADDR: begin
            ctrl.pc_en    = 1'b1;
            ctrl.mar_load = 1'b1;
         end
         S_F_WAIT: begin
            ctrl.ram_rd  = 1'b1;
            ctrl.ir_load = mem_ready_i;
            ctrl.pc_inc  = mem_ready_i;
         end
         S_DECODE: ctrl.pc_load = (ir_op_i == OP_JMP);
         S_X_ADDR: begin
            ctrl.mar_load = 1'b1;
            ctrl.mar_sel  = 1'b1;
         end
         S_X_WAIT: begin
            ctrl.ram_rd = 1'b1;
            if (mem_ready_i) begin
               ctrl.alu_op    = alu_of(op_q);
               ctrl.a_load    = (op_q == OP_LDA);
               ctrl.b_load    = (op_q == OP_LDB) || (op_q == OP_ADD) || (op_q == OP_SUB);
               ctrl.alu_start = is_multi(op_q);
            end
         end
         S_X_ALU: begin
            ctrl.alu_op = alu_of(op_q);
            ctrl.b_load = alu_done_i;
         end
         default: ctrl = '0;
      endcase
   end

   assign pc_en_o     = ctrl.pc_en;
   assign pc_inc_o    = ctrl.pc_inc;
   assign pc_load_o   = ctrl.pc_load;
   assign mar_load_o  = ctrl.mar_load;
   assign mar_sel_o   = ctrl.mar_sel;
   assign ram_rd_o    = ctrl.ram_rd;
   assign ir_load_o   = ctrl.ir_load;
   assign a_load_o    = ctrl.a_load;
   assign b_load_o    = ctrl.b_load;
   assign alu_op_o    = ctrl.alu_op;
   assign alu_start_o = ctrl.alu_start;
   // The PC loads at the end of DECODE, before the address register has captured it
   assign jmp_addr_o  = (state_q == S_DECODE) ? ir_addr_i : addr_q;
   assign halted_o    = halted_q;
   assign fault_o     = fault_q;
   assign instr_cnt_o = cnt_q;

endmodule
